dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Two-port arbiter sharing the single-port 256x8 data memory between the core load/store unit (port 0) and a secondary requester such as the loader/DMA engine (port 1). At most one access is granted per clock. Grant is round-robin, with an optional bounded lock for bursts. Memory reads are combinational; the arbiter registers read data and returns it one cycle after the grant. It sits directly in front of the data memory, and its memory-side outputs drive that memory's write enable, address and write data.

## Interface
Parameters:
- AW, 8, address width (256-deep memory)
- DW, 8, data width
- LOCK_MAX, 16, max consecutive locked grants to one port while the other port is requesting (range 1..255)

Ports:
- clk  input  1  single clock, all state on rising edge
- reset  input  1  synchronous, active-high
- p0_req / p1_req  input  1  access request, level; held until granted
- p0_we / p1_we  input  1  1 = write, 0 = read; valid while req
- p0_lock / p1_lock  input  1  keep grant on following cycles (burst)
- p0_addr / p1_addr  input  AW  address
- p0_wdata / p1_wdata  input  DW  write data
- p0_gnt / p1_gnt  output  1  combinational; the access completes at this clock edge
- p0_rvalid / p1_rvalid  output  1  registered; read data valid, one-cycle pulse
- p0_rdata / p1_rdata  output  DW  registered read data; holds last value
- mem_write_en  output  1  to memory write enable
- mem_addr  output  AW  to memory address
- mem_data_in  output  DW  to memory write data
- mem_data_out  input  DW  combinational read data from memory

## Operation
- Transfer rule: a transfer occurs on a rising edge where pN_req && pN_gnt. The requester may change req/we/addr/wdata after that edge.
- Grant exclusion: p0_gnt and p1_gnt are never both 1. When neither port is granted, the memory outputs are mem_write_en=0, mem_addr=0 and mem_data_in=0.
- Memory mux: the granted port drives mem_addr and mem_data_in. mem_write_en = gnt && we for the granted port.
- Write: committed at the grant edge. rvalid stays 0.
- Read: at the grant edge, mem_data_out is captured into pN_rdata, and pN_rvalid=1 for exactly the next cycle.
- Arbitration (combinational, from registered state):
  - Only one port requesting: that port is granted.
  - Both requesting, no active lock: grant the port other than last_gnt.
  - Both requesting, active lock held by port L: grant L while lock_cnt < LOCK_MAX. At lock_cnt == LOCK_MAX, grant the other port. This forced switch resets lock_cnt.
- State:
  - last_gnt (1 bit): updated to the granted port on every transfer.
  - lock_owner_valid and lock_owner: set on a transfer with pN_lock=1. Cleared on a transfer without lock, on a forced switch, or when the owner drops req.
  - lock_cnt (8 bit): increments on each locked transfer while the other port is requesting. Clears when the other port is idle or the owner changes. Saturates at LOCK_MAX.
- No transfer (no req): all state holds, except that the lock is released if the owner's req is low.

## Timing
- Reset (sync) values: p0/p1_gnt=0 and mem_write_en=0 while reset is high, regardless of req.
- Registered state after the reset edge: last_gnt=1 (port 0 wins the first tie), lock cleared, lock_cnt=0, p0/p1_rvalid=0, p0/p1_rdata=0.
- Read latency: grant edge + 1 cycle to rvalid/rdata.
- Write latency: data is in memory after the grant edge, so a read granted on the next cycle returns the new value.
- Back-to-back: one transfer per cycle sustained. Alternating ports when both continuously request without lock.
- Same-address, different ports, consecutive cycles: strictly ordered by grant order.
- Reset mid-read: rvalid due on the reset cycle is suppressed (forced 0). A pending grant is dropped with no memory write.
- Address wrap: none. Addresses are full AW-bit and map 1:1.

## Structure
- Shared package: AW/DW defaults, port-id constants PORT_CORE=0 and PORT_DMA=1, LOCK_MAX default.
- Sub-module: rr_pick2. Combinational two-request picker with inputs req[1:0], last_gnt, lock_valid, lock_owner and force_switch, and output one-hot gnt[1:0].
- Top level holds the lock counter, last_gnt, the rdata/rvalid registers and the memory mux.
- Estimated size: ~180 lines.

## Test plan
- Reset with p0_req=p1_req=1 held: gnt=0 throughout reset. First cycle after reset, p0_gnt=1; next cycle, p1_gnt=1.
- p0 writes 0xA5 to addr 0x10, then p1 reads 0x10 the next cycle: p1_rvalid=1 one cycle after its grant with p1_rdata=0xA5, and p0_rvalid stays 0.
- Both ports continuously request 8 reads, no lock: grants alternate 0,1,0,1…; each rvalid arrives one cycle after its own grant with correct data.
- p1 holds lock and req with p0 requesting, LOCK_MAX=4: p1 granted 4 consecutive cycles, then p0 granted, then p1 regains.
- Reset asserted on the cycle after a p0 read grant of addr 0x20: p0_rvalid stays 0, p0_rdata=0, and no write is observed at mem_write_en.
- Only p1 requests, write 0x3C to 0xFF: p1_gnt in the same cycle, mem_write_en=1, mem_addr=0xFF, mem_data_in=0x3C. A later read of 0xFF returns 0x3C.

Source files
------------

// File: rtl/dmem_arbiter_pkg.sv
// Shared constants for the data-memory arbiter: default widths, port ids, lock bound.
// Pure declarations; no timing or flow control of its own.
package dmem_arbiter_pkg;

    localparam int AW_DEF       = 8;
    localparam int DW_DEF       = 8;
    localparam int LOCK_MAX_DEF = 16;

    localparam logic PORT_CORE = 1'b0;
    localparam logic PORT_DMA  = 1'b1;

    function automatic logic other_port(input logic p);
        return ~p;
    endfunction

endpackage

// File: rtl/dmem_arbiter_pick.sv
// Two-request one-hot picker: round-robin tie break, honouring a held lock unless forced off.
// Purely combinational; a port that is not picked simply keeps requesting.
module rr_pick2 (
    input  logic [1:0] req,
    input  logic       last_gnt,
    input  logic       lock_valid,
    input  logic       lock_owner,
    input  logic       force_switch,
    output logic [1:0] gnt
);

    logic winner;

    always_comb begin
        winner = 1'b0;
        gnt    = 2'b00;
        case (req)
            2'b01: gnt = 2'b01;
            2'b10: gnt = 2'b10;
            2'b11: begin
                if (lock_valid) begin
                    winner = force_switch ? ~lock_owner : lock_owner;
                end else begin
                    winner = ~last_gnt;
                end
                gnt = winner ? 2'b10 : 2'b01;
            end
            default: gnt = 2'b00;
        endcase
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of a single-port data memory; one access per clock.
// Grant is combinational, read data returns one cycle after grant; losers hold req until granted.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int AW       = AW_DEF,
    parameter int DW       = DW_DEF,
    parameter int LOCK_MAX = LOCK_MAX_DEF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          p0_req,
    input  logic          p0_we,
    input  logic          p0_lock,
    input  logic [AW-1:0] p0_addr,
    input  logic [DW-1:0] p0_wdata,
    output logic          p0_gnt,
    output logic          p0_rvalid,
    output logic [DW-1:0] p0_rdata,
    input  logic          p1_req,
    input  logic          p1_we,
    input  logic          p1_lock,
    input  logic [AW-1:0] p1_addr,
    input  logic [DW-1:0] p1_wdata,
    output logic          p1_gnt,
    output logic          p1_rvalid,
    output logic [DW-1:0] p1_rdata,
    output logic          mem_write_en,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_data_in,
    input  logic [DW-1:0] mem_data_out
);

    localparam logic [7:0] LOCK_MAX_C = 8'(LOCK_MAX);

    logic          last_gnt_q,  last_gnt_d;
    logic          lock_vld_q,  lock_vld_d;
    logic          lock_own_q,  lock_own_d;
    logic [7:0]    lock_cnt_q,  lock_cnt_d;
    logic [1:0]    rvalid_q,    rvalid_d;
    logic [DW-1:0] p0_rdata_q,  p0_rdata_d;
    logic [DW-1:0] p1_rdata_q,  p1_rdata_d;

    logic [1:0] req, lock_in, we_in, gnt_raw, gnt;
    logic       force_switch, xfer, win, win_we;

    assign req     = {p1_req,  p0_req};
    assign lock_in = {p1_lock, p0_lock};
    assign we_in   = {p1_we,   p0_we};

    // A lock only counts while its owner is still asking for the memory.
    assign force_switch = lock_vld_q && req[lock_own_q] && (&req) && (lock_cnt_q >= LOCK_MAX_C);

    rr_pick2 u_pick (
        .req          (req),
        .last_gnt     (last_gnt_q),
        .lock_valid   (lock_vld_q && req[lock_own_q]),
        .lock_owner   (lock_own_q),
        .force_switch (force_switch),
        .gnt          (gnt_raw)
    );

    assign gnt    = reset ? 2'b00 : gnt_raw;
    assign p0_gnt = gnt[PORT_CORE];
    assign p1_gnt = gnt[PORT_DMA];
    assign xfer   = |gnt;
    assign win    = gnt[PORT_DMA];
    assign win_we = we_in[win];

    always_comb begin
        mem_write_en = 1'b0;
        mem_addr     = '0;
        mem_data_in  = '0;
        if (gnt[PORT_CORE]) begin
            mem_write_en = p0_we;
            mem_addr     = p0_addr;
            mem_data_in  = p0_wdata;
        end else if (gnt[PORT_DMA]) begin
            mem_write_en = p1_we;
            mem_addr     = p1_addr;
            mem_data_in  = p1_wdata;
        end
    end

    always_comb begin
        last_gnt_d = last_gnt_q;
        lock_vld_d = lock_vld_q;
        lock_own_d = lock_own_q;
        lock_cnt_d = lock_cnt_q;
        rvalid_d   = 2'b00;
        p0_rdata_d = p0_rdata_q;
        p1_rdata_d = p1_rdata_q;
        if (xfer) begin
            last_gnt_d = win;
            if (force_switch) begin
                lock_vld_d = 1'b0;
                lock_cnt_d = '0;
            end else if (lock_in[win]) begin
                lock_vld_d = 1'b1;
                lock_own_d = win;
                // Only time spent starving the other port counts toward the bound.
                if (!req[other_port(win)]) begin
                    lock_cnt_d = '0;
                end else if (lock_vld_q && lock_own_q == win) begin
                    lock_cnt_d = (lock_cnt_q >= LOCK_MAX_C) ? LOCK_MAX_C : lock_cnt_q + 8'd1;
                end else begin
                    lock_cnt_d = 8'd1;
                end
            end else begin
                lock_vld_d = 1'b0;
                lock_cnt_d = '0;
            end
            if (!win_we) begin
                rvalid_d[win] = 1'b1;
                if (win == PORT_CORE) p0_rdata_d = mem_data_out;
                else                  p1_rdata_d = mem_data_out;
            end
        end else begin
            if (!req[lock_own_q])             lock_vld_d = 1'b0;
            if (!req[other_port(lock_own_q)]) lock_cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_gnt_q <= PORT_DMA;
            lock_vld_q <= 1'b0;
            lock_own_q <= PORT_CORE;
            lock_cnt_q <= '0;
            rvalid_q   <= 2'b00;
            p0_rdata_q <= '0;
            p1_rdata_q <= '0;
        end else begin
            last_gnt_q <= last_gnt_d;
            lock_vld_q <= lock_vld_d;
            lock_own_q <= lock_own_d;
            lock_cnt_q <= lock_cnt_d;
            rvalid_q   <= rvalid_d;
            p0_rdata_q <= p0_rdata_d;
            p1_rdata_q <= p1_rdata_d;
        end
    end

    // A read completing just before reset must not be reported during the reset cycle.
    assign p0_rvalid = rvalid_q[PORT_CORE] & ~reset;
    assign p1_rvalid = rvalid_q[PORT_DMA]  & ~reset;
    assign p0_rdata  = p0_rdata_q;
    assign p1_rdata  = p1_rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomised plus directed bench for dmem_arbiter against a behavioural reference model.
module tb_dmem_arbiter;

    localparam int LMAX = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] req, we, lock;
    logic [7:0] addr [2];
    logic [7:0] wdata [2];

    logic       p0_gnt, p1_gnt, p0_rvalid, p1_rvalid;
    logic [7:0] p0_rdata, p1_rdata;
    logic       mem_write_en;
    logic [7:0] mem_addr, mem_data_in, mem_data_out;

    logic [7:0] mem     [256];
    logic [7:0] ref_mem [256];

    int n_total = 0;
    int n_bad   = 0;

    // reference model state
    int       m_last, m_owner, m_cnt, exp_g;
    bit       m_lock_vld;
    bit [1:0] m_rv;
    bit [7:0] m_rd [2];
    bit [1:0] got;
    int       hist [$];

    always #5 clk = ~clk;

    dmem_arbiter #(.AW(8), .DW(8), .LOCK_MAX(LMAX)) dut (
        .clk          (clk),
        .reset        (reset),
        .p0_req       (req[0]),
        .p0_we        (we[0]),
        .p0_lock      (lock[0]),
        .p0_addr      (addr[0]),
        .p0_wdata     (wdata[0]),
        .p0_gnt       (p0_gnt),
        .p0_rvalid    (p0_rvalid),
        .p0_rdata     (p0_rdata),
        .p1_req       (req[1]),
        .p1_we        (we[1]),
        .p1_lock      (lock[1]),
        .p1_addr      (addr[1]),
        .p1_wdata     (wdata[1]),
        .p1_gnt       (p1_gnt),
        .p1_rvalid    (p1_rvalid),
        .p1_rdata     (p1_rdata),
        .mem_write_en (mem_write_en),
        .mem_addr     (mem_addr),
        .mem_data_in  (mem_data_in),
        .mem_data_out (mem_data_out)
    );

    assign mem_data_out = mem[mem_addr];
    always @(posedge clk) if (mem_write_en) mem[mem_addr] <= mem_data_in;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int ref_pick(input bit r0, input bit r1);
        if (!r0 && !r1) return -1;
        if (r0 && !r1)  return 0;
        if (r1 && !r0)  return 1;
        if (m_lock_vld) return (m_cnt < LMAX) ? m_owner : 1 - m_owner;
        return 1 - m_last;
    endfunction

    task automatic check_all();
        int obs_g;
        exp_g = reset ? -1 : ref_pick(req[0], req[1]);
        check_eq("gnt0", p0_gnt, exp_g == 0);
        check_eq("gnt1", p1_gnt, exp_g == 1);
        if (exp_g >= 0) begin
            check_eq("mem_we",   mem_write_en, we[exp_g]);
            check_eq("mem_addr", mem_addr,     addr[exp_g]);
            check_eq("mem_din",  mem_data_in,  wdata[exp_g]);
        end else begin
            check_eq("mem_we_idle",   mem_write_en, 0);
            check_eq("mem_addr_idle", mem_addr,     0);
            check_eq("mem_din_idle",  mem_data_in,  0);
        end
        check_eq("rvalid0", p0_rvalid, m_rv[0] && !reset);
        check_eq("rvalid1", p1_rvalid, m_rv[1] && !reset);
        check_eq("rdata0",  p0_rdata,  m_rd[0]);
        check_eq("rdata1",  p1_rdata,  m_rd[1]);
        obs_g = p0_gnt ? 0 : (p1_gnt ? 1 : -1);
        hist.push_back(obs_g);
    endtask

    task automatic model_update();
        int  g;
        bit  forced;
        got = 2'b00;
        if (reset) begin
            m_last = 1; m_lock_vld = 0; m_owner = 0; m_cnt = 0;
            m_rv = 2'b00; m_rd[0] = 0; m_rd[1] = 0;
        end else begin
            m_rv = 2'b00;
            if (exp_g >= 0) begin
                g = exp_g;
                got[g] = 1'b1;
                forced = m_lock_vld && (m_owner != g) && req[0] && req[1];
                if (we[g]) ref_mem[addr[g]] = wdata[g];
                else begin
                    m_rv[g] = 1'b1;
                    m_rd[g] = ref_mem[addr[g]];
                end
                m_last = g;
                if (forced) begin
                    m_lock_vld = 0; m_cnt = 0;
                end else if (lock[g]) begin
                    if (!req[1-g])                          m_cnt = 0;
                    else if (m_lock_vld && m_owner == g)    m_cnt = (m_cnt + 1 > LMAX) ? LMAX : m_cnt + 1;
                    else                                    m_cnt = 1;
                    m_lock_vld = 1; m_owner = g;
                end else begin
                    m_lock_vld = 0; m_cnt = 0;
                end
            end else begin
                if (!req[m_owner])   m_lock_vld = 0;
                if (!req[1-m_owner]) m_cnt = 0;
            end
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        check_all();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic set_port(input int p, input bit r, input bit w, input bit l,
                            input logic [7:0] a, input logic [7:0] d);
        req[p] = r; we[p] = w; lock[p] = l; addr[p] = a; wdata[p] = d;
    endtask

    task automatic drive_random();
        for (int p = 0; p < 2; p++) begin
            if (!req[p] || got[p])
                set_port(p, $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
                         $urandom_range(0, 2) == 0, 8'($urandom_range(0, 15)), 8'($urandom));
        end
        reset = ($urandom_range(0, 199) == 0);
    endtask

    initial begin
        int base;
        int exp_lock [6];
        logic [7:0] v;
        for (int i = 0; i < 256; i++) begin
            v = 8'($urandom);
            mem[i] = v; ref_mem[i] = v;
        end
        reset = 1'b1;
        set_port(0, 1, 0, 0, 8'h01, 8'h00);
        set_port(1, 1, 0, 0, 8'h02, 8'h00);
        @(posedge clk); model_update(); #1;

        // reset held with both requesting, then first tie goes to port 0
        repeat (3) cycle();
        reset = 1'b0;
        base = hist.size();
        cycle();
        cycle();
        check_eq("first_after_reset", hist[base],   0);
        check_eq("second_after_reset", hist[base+1], 1);
        set_port(0, 0, 0, 0, 8'h00, 8'h00);
        set_port(1, 0, 0, 0, 8'h00, 8'h00);
        cycle();

        // p0 writes, p1 reads the same address on the next cycle
        set_port(0, 1, 1, 0, 8'h10, 8'hA5);
        cycle();
        set_port(0, 0, 0, 0, 8'h00, 8'h00);
        set_port(1, 1, 0, 0, 8'h10, 8'h00);
        cycle();
        set_port(1, 0, 0, 0, 8'h00, 8'h00);
        check_eq("wr_rd_p1_rvalid", p1_rvalid, 1);
        check_eq("wr_rd_p1_rdata",  p1_rdata,  8'hA5);
        check_eq("wr_rd_p0_rvalid", p0_rvalid, 0);
        cycle();

        // continuous reads from both ports alternate
        set_port(0, 1, 0, 0, 8'h40, 8'h00);
        set_port(1, 1, 0, 0, 8'h80, 8'h00);
        base = hist.size();
        for (int i = 0; i < 8; i++) begin
            cycle();
            for (int p = 0; p < 2; p++) if (got[p]) addr[p] = addr[p] + 8'd1;
        end
        for (int i = 1; i < 8; i++) check_eq("alternate", hist[base+i], 1 - hist[base+i-1]);
        set_port(0, 0, 0, 0, 8'h00, 8'h00);
        set_port(1, 0, 0, 0, 8'h00, 8'h00);
        cycle();

        // p1 burst lock bounded at LMAX grants while p0 waits
        set_port(0, 1, 0, 0, 8'h05, 8'h00);
        cycle();
        set_port(1, 1, 0, 1, 8'h06, 8'h00);
        base = hist.size();
        for (int i = 0; i < 6; i++) cycle();
        exp_lock = '{1, 1, 1, 1, 0, 1};
        for (int i = 0; i < 6; i++) check_eq("lock_seq", hist[base+i], exp_lock[i]);
        set_port(0, 0, 0, 0, 8'h00, 8'h00);
        set_port(1, 0, 0, 0, 8'h00, 8'h00);
        cycle();

        // reset in the cycle after a read grant; a pending write is dropped
        set_port(0, 1, 0, 0, 8'h20, 8'h00);
        cycle();
        set_port(0, 0, 0, 0, 8'h00, 8'h00);
        set_port(1, 1, 1, 0, 8'h21, 8'h77);
        reset = 1'b1;
        #1;
        check_eq("rst_p0_rvalid", p0_rvalid,    0);
        check_eq("rst_mem_we",    mem_write_en, 0);
        check_eq("rst_p1_gnt",    p1_gnt,       0);
        cycle();
        reset = 1'b0;
        set_port(1, 0, 0, 0, 8'h00, 8'h00);
        #1;
        check_eq("post_rst_rdata0",  p0_rdata,  0);
        check_eq("post_rst_rvalid0", p0_rvalid, 0);
        cycle();

        // p1 alone writes the top address, then reads it back
        set_port(1, 1, 1, 0, 8'hFF, 8'h3C);
        #1;
        check_eq("top_p1_gnt",   p1_gnt,       1);
        check_eq("top_mem_we",   mem_write_en, 1);
        check_eq("top_mem_addr", mem_addr,     8'hFF);
        check_eq("top_mem_din",  mem_data_in,  8'h3C);
        cycle();
        set_port(1, 1, 0, 0, 8'hFF, 8'h00);
        cycle();
        set_port(1, 0, 0, 0, 8'h00, 8'h00);
        check_eq("top_rdata", p1_rdata, 8'h3C);
        cycle();

        got = 2'b11;
        for (int i = 0; i < 3000; i++) begin
            drive_random();
            cycle();
        end
        reset = 1'b0;
        cycle();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
